// File: rtl/move_request_gen_if.sv
// Key inputs and move-request outputs between the board keys, the request generator and the movement FSM.
// The master side drives the keys and consumes the requests; the slave side is the generator.
interface move_request_gen_if;
  logic KeyLeft;
  logic KeyRight;
  logic LeftIn;
  logic RightIn;
  logic Held;

  modport master (output KeyLeft, output KeyRight, input LeftIn, input RightIn, input Held);
  modport slave  (input KeyLeft, input KeyRight, output LeftIn, output RightIn, output Held);
endinterface

// File: rtl/move_request_gen.sv
// Sync + debounce two active-low keys into single-cycle move pulses; hold-to-repeat when MOVE_REQUEST_AUTOREPEAT_EN is defined.
// Press-to-pulse latency DEBOUNCE_CYCLES+3 edges; no backpressure, pulses are fire-and-forget.
module move_request_gen #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic               Clock,
  input  logic               Reset,
  move_request_gen_if.slave  io
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FIRE       = 2'd1,
    HOLD_DELAY = 2'd2
`ifdef MOVE_REQUEST_AUTOREPEAT_EN
    , HOLD_REPEAT = 2'd3
`endif
  } state_t;

  typedef enum logic {LEFT = 1'b0, RIGHT = 1'b1} dir_t;

  // Bit 0 is the left key, bit 1 the right key, everywhere below.
  logic [1:0]         sync1_q, sync1_d;
  logic [1:0]         sync2_q, sync2_d;
  logic [1:0]         deb_q, deb_d;
  logic [1:0][DW-1:0] db_cnt_q, db_cnt_d;

  state_t state_q, state_d;
  dir_t   dir_q, dir_d;
  logic   left_q, left_d;
  logic   right_q, right_d;
  logic   held_q, held_d;

`ifdef MOVE_REQUEST_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX);
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

  logic d_left, d_right, key_dir, key_opp;

  assign d_left  = deb_q[0];
  assign d_right = deb_q[1];
  assign key_dir = (dir_q == LEFT) ? d_left  : d_right;
  assign key_opp = (dir_q == LEFT) ? d_right : d_left;

  always_comb begin
    sync1_d = {~io.KeyRight, ~io.KeyLeft};
    sync2_d = sync1_q;
    deb_d    = deb_q;
    db_cnt_d = db_cnt_q;
    for (int k = 0; k < 2; k++) begin
      if (sync2_q[k] == deb_q[k]) begin
        db_cnt_d[k] = '0;
      end else if (db_cnt_q[k] == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d[k]    = ~deb_q[k];
        db_cnt_d[k] = '0;
      end else begin
        db_cnt_d[k] = db_cnt_q[k] + DW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    left_d  = 1'b0;
    right_d = 1'b0;
`ifdef MOVE_REQUEST_AUTOREPEAT_EN
    rpt_cnt_d = rpt_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        // Both keys down is ambiguous, so only a lone key starts a move.
        if (d_left ^ d_right) begin
          dir_d   = d_left ? LEFT : RIGHT;
          left_d  = d_left;
          right_d = d_right;
          state_d = FIRE;
`ifdef MOVE_REQUEST_AUTOREPEAT_EN
          rpt_cnt_d = RW'(REPEAT_DELAY - 1);
`endif
        end
      end
      FIRE: begin
        state_d = HOLD_DELAY;
`ifdef MOVE_REQUEST_AUTOREPEAT_EN
        rpt_cnt_d = rpt_cnt_q - RW'(1);
`endif
      end
`ifdef MOVE_REQUEST_AUTOREPEAT_EN
      HOLD_DELAY, HOLD_REPEAT: begin
        // Release or opposite key wins over a repeat due in the same cycle.
        if (!key_dir || key_opp) begin
          state_d = IDLE;
        end else if (rpt_cnt_q == '0) begin
          left_d    = (dir_q == LEFT);
          right_d   = (dir_q == RIGHT);
          rpt_cnt_d = RW'(REPEAT_PERIOD - 1);
          state_d   = HOLD_REPEAT;
        end else begin
          rpt_cnt_d = rpt_cnt_q - RW'(1);
        end
      end
`else
      HOLD_DELAY: begin
        if (!key_dir || key_opp) begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef MOVE_REQUEST_AUTOREPEAT_EN
    held_d = (state_d == HOLD_DELAY) || (state_d == HOLD_REPEAT);
`else
    held_d = (state_d == HOLD_DELAY);
`endif
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      db_cnt_q <= '0;
      state_q  <= IDLE;
      dir_q    <= LEFT;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      held_q   <= 1'b0;
`ifdef MOVE_REQUEST_AUTOREPEAT_EN
      rpt_cnt_q <= '0;
`endif
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      deb_q    <= deb_d;
      db_cnt_q <= db_cnt_d;
      state_q  <= state_d;
      dir_q    <= dir_d;
      left_q   <= left_d;
      right_q  <= right_d;
      held_q   <= held_d;
`ifdef MOVE_REQUEST_AUTOREPEAT_EN
      rpt_cnt_q <= rpt_cnt_d;
`endif
    end
  end

  assign io.LeftIn  = left_q;
  assign io.RightIn = right_q;
  assign io.Held    = held_q;

endmodule

// File: doc/move_request_gen.md
# move_request_gen

Input-side conditioner that produces the `LeftIn`/`RightIn` move requests consumed by the character-position state machine. It takes two raw, asynchronous, active-low push-button inputs and synchronizes and debounces them. It then emits clean single-cycle move pulses, with optional hold-to-repeat. It sits between the board keys and the movement FSM, in the same clock domain as that FSM.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synchronized samples required before the debounced level changes; minimum 1.
- `REPEAT_DELAY`, default 12500000: cycles from a move pulse to the first auto-repeat pulse; minimum 2.
- `REPEAT_PERIOD`, default 5000000: cycles between later auto-repeat pulses; minimum 2.
- `Clock`, input, 1: single clock; all logic is rising-edge.
- `Reset`, input, 1: asynchronous, active-high reset.
- `KeyLeft`, input, 1: raw left button, active-low, asynchronous to `Clock`.
- `KeyRight`, input, 1: raw right button, active-low, asynchronous to `Clock`.
- `LeftIn`, output, 1: registered single-cycle move-left request.
- `RightIn`, output, 1: registered single-cycle move-right request.
- `Held`, output, 1: registered; high while the FSM is in `HOLD_DELAY` or `HOLD_REPEAT`.

## Operation
- **Synchronizer:** each key is inverted to active-high, then passes through a 2-flop synchronizer. Both synchronizer flops reset to 0, meaning "released".
- **Debouncer:** one per key.
  - The counter is `$clog2(DEBOUNCE_CYCLES+1)` bits wide.
  - It clears whenever the synchronized sample equals the debounced level.
  - It increments while the sample differs from the debounced level.
  - When the count reaches `DEBOUNCE_CYCLES`, the debounced level toggles and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles leaves the debounced level unchanged.
- **Direction FSM** (registered `dir`: `LEFT`/`RIGHT`; debounced levels `dL`, `dR`):
  - `IDLE`: if exactly one of `dL`/`dR` is 1, latch `dir` and go to `FIRE`; otherwise stay in `IDLE`.
  - `FIRE`: assert `LeftIn` (if `dir=LEFT`) or `RightIn` (if `dir=RIGHT`) for exactly one cycle. Load the repeat counter with `REPEAT_DELAY-1` and go to `HOLD_DELAY`.
  - `HOLD_DELAY` / `HOLD_REPEAT`: decrement the counter each cycle.
    - At count 0: pulse the `dir` output for one cycle, load `REPEAT_PERIOD-1`, and go to (or stay in) `HOLD_REPEAT`.
  - **Exit from any `HOLD_*` state:** go to `IDLE` with no pulse if the `dir` key's debounced level falls, or if the opposite key's debounced level becomes 1.
  - The repeat counter is `$clog2(max(REPEAT_DELAY,REPEAT_PERIOD))` bits wide.
- **Invariant:** `LeftIn` and `RightIn` are never high in the same cycle.
- **Both keys held:** no pulses are produced. When one key is released, the key still held is treated as a fresh press, so `IDLE` → `FIRE` follows.
- **Simultaneous debounced press of both keys in the same cycle:** no pulse; the FSM stays in `IDLE`.

## Timing
- **Reset values:** `LeftIn`=0, `RightIn`=0, `Held`=0, FSM=`IDLE`, all counters=0, debounced levels=0.
  - Outputs clear immediately on `Reset` assertion, including in the middle of a pulse or a hold.
  - After `Reset` deasserts, a key held throughout reset produces a pulse once it has been debounced.
- **Press latency:** from the first `Clock` edge that samples a key low to the corresponding output going high is `DEBOUNCE_CYCLES + 3` edges. This is 2 synchronizer edges, `DEBOUNCE_CYCLES` debounce edges, and 1 FSM edge.
- **Repeat timing:** if the first pulse is in cycle P, auto-repeat pulses occur in cycles P+`REPEAT_DELAY`, then P+`REPEAT_DELAY`+k·`REPEAT_PERIOD` for k ≥ 1.
- **Release latency:** from the first edge that samples the key high to FSM=`IDLE` (`Held`=0) is `DEBOUNCE_CYCLES + 3` edges. A repeat pulse scheduled before that point is still emitted.
- **Pulse spacing:** two pulses are never closer than 2 cycles apart, so the downstream FSM moves at most one position per pulse.

## Configuration
- Macro: `MOVE_REQUEST_AUTOREPEAT_EN`.
- **Defined:** behaviour is exactly as described above.
- **Undefined:**
  - The `HOLD_REPEAT` state and the repeat counter are not compiled in.
  - `FIRE` goes to `HOLD_DELAY`, which is a wait-for-release state with no counting and no further pulses.
  - Exactly one pulse is produced per debounced press.
  - `Held` still reflects the `HOLD_DELAY` state.
  - `REPEAT_DELAY` and `REPEAT_PERIOD` are ignored.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=5.
- **Reset:** assert `Reset` mid-sim with `KeyLeft`=0 → `LeftIn`/`RightIn`/`Held`=0 in the same cycle. After deassert, `LeftIn` pulses 7 edges later.
- **Single press:** drive `KeyRight` low for 8 cycles, then high → exactly one `RightIn` pulse, 1 cycle wide, 7 edges after the press; `LeftIn` stays 0.
- **Bounce:** toggle `KeyLeft` low/high every 2 cycles for 20 cycles, then leave it high → no pulses.
- **Auto-repeat:** hold `KeyLeft` low for 40 cycles → `LeftIn` pulses at P, P+10, P+15, P+20, … up to release detection, then none. With the macro undefined, only P.
- **Both keys:** press `KeyLeft`, then press `KeyRight` 20 cycles later, then release `KeyLeft` 20 cycles after that.
  - Required: one `LeftIn` pulse; the hold is aborted when `RightIn` debounces; no pulses while both are held; one `RightIn` pulse 7 edges after `KeyLeft` is released.
- **Simultaneous press:** drop both keys low in the same cycle and hold for 30 cycles → no pulses, FSM stays in `IDLE`.
